trdb_packet_emitter_mc: RTL

Multi-channel, parametrised packet emitter for the trace debugger. It arbitrates between one instruction-trace request channel, NSW software-word channels and one timer channel, and formats the winning request into a packet. The emitter compresses trace addresses itself (differential or full, then sign-compressed), instead of taking a keep-bit count from upstream. Formatted packets go into a DEPTH-entry output FIFO drained through a valid/ready handshake towards the packet streamer.

---
 rtl/trdb_pkg.sv | 73 +++++++
 rtl/trdb_packet_fifo.sv | 48 ++++
 rtl/trdb_packet_emitter_mc.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// Shared trace-debugger types, packet geometry and address-compression helpers.
package trdb_pkg;

  localparam int unsigned PRIVLEN  = 2;
  localparam int unsigned CAUSELEN = 5;
  localparam int unsigned LEN_W    = 7;
  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [1:0] {
    W_EMPTY    = 2'd0,
    W_TIME     = 2'd1,
    W_TRACE    = 2'd2,
    W_SOFTWARE = 2'd3
  } trdb_msg_t;

  typedef enum logic [1:0] {
    F_BRANCH_FULL = 2'd0,
    F_BRANCH_DIFF = 2'd1,
    F_ADDR_ONLY   = 2'd2,
    F_SYNC        = 2'd3
  } trdb_format_t;

  typedef enum logic [1:0] {
    SF_START     = 2'd0,
    SF_EXCEPTION = 2'd1,
    SF_CONTEXT   = 2'd2,
    SF_UNDEF     = 2'd3
  } trdb_subformat_t;

  localparam logic [LEN_W-1:0] BMAP_LEN_0 = 7'd1;
  localparam logic [LEN_W-1:0] BMAP_LEN_1 = 7'd9;
  localparam logic [LEN_W-1:0] BMAP_LEN_2 = 7'd17;
  localparam logic [LEN_W-1:0] BMAP_LEN_3 = 7'd25;
  localparam logic [LEN_W-1:0] BMAP_LEN_4 = 7'd31;

  function automatic int unsigned packet_len(input int unsigned xlen);
    return 2 + 2 + 5 + 31 + xlen;
  endfunction

  localparam int unsigned PACKET_LEN_MAX = packet_len(XLEN_MAX);

  // Sized for the widest configuration; the top narrows it to its own XLEN.
  typedef struct packed {
    logic [PACKET_LEN_MAX-1:0] bits;
    logic [LEN_W-1:0]          len;
  } trdb_packet_t;

  // Smallest n such that sign-extending val[n-1:0] reproduces val[xlen-1:0].
  function automatic logic [LEN_W-1:0] sign_compress_len(input logic [63:0] val,
                                                         input int unsigned xlen);
    logic [LEN_W-1:0] keep;
    logic             stop;
    keep = LEN_W'(xlen);
    stop = 1'b0;
    for (int unsigned n = 63; n >= 1; n--) begin
      if (n < xlen && !stop) begin
        if (val[n-1] == val[xlen-1]) keep = LEN_W'(n);
        else                         stop = 1'b1;
      end
    end
    return keep;
  endfunction

  function automatic logic [LEN_W-1:0] branch_map_len(input logic [4:0] cnt);
    if (cnt == 5'd0)       return BMAP_LEN_4;
    else if (cnt <= 5'd1)  return BMAP_LEN_0;
    else if (cnt <= 5'd9)  return BMAP_LEN_1;
    else if (cnt <= 5'd17) return BMAP_LEN_2;
    else if (cnt <= 5'd25) return BMAP_LEN_3;
    else                   return BMAP_LEN_4;
  endfunction

endpackage

// File: rtl/trdb_packet_fifo.sv
// Packet FIFO: push while full is accepted only alongside a pop; pop on empty is ignored.
module trdb_packet_fifo
  import trdb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = trdb_packet_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic empty_o,
  output logic full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T                mem [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  logic            pop_eff, push_eff;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == (AW+1)'(DEPTH));
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);
  assign data_o   = empty_o ? '0 : mem[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_eff) wr_q <= wr_q + 1'b1;
      if (pop_eff)  rd_q <= rd_q + 1'b1;
      if (push_eff && !pop_eff)      cnt_q <= cnt_q + 1'b1;
      else if (pop_eff && !push_eff) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) mem[wr_q] <= data_i;
  end

endmodule

// File: rtl/trdb_packet_emitter_mc.sv
// Arbitrates trace / software / timer requests, compresses trace addresses
// and queues formatted packets for the packet streamer.
module trdb_packet_emitter_mc
  import trdb_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NSW         = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMER_WIDTH = 40,
  localparam int unsigned PACKET_LEN = packet_len(XLEN)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     trace_valid_i,
  output logic                     trace_ready_o,
  input  logic [1:0]               trace_format_i,
  input  logic [1:0]               trace_subformat_i,
  input  logic                     use_full_addr_i,
  input  logic [XLEN-1:0]          iaddr_i,
  input  logic [PRIVLEN-1:0]       priv_i,
  input  logic                     is_branch_i,
  input  logic                     interrupt_i,
  input  logic [CAUSELEN-1:0]      cause_i,
  input  logic                     lc_u_discontinuity_i,
  input  logic [30:0]              branch_map_i,
  input  logic [4:0]               branch_map_cnt_i,
  input  logic                     branch_map_full_i,
  output logic                     branch_map_flush_o,
  input  logic [NSW-1:0]           sw_valid_i,
  input  logic [NSW*32-1:0]        sw_word_i,
  output logic [NSW-1:0]           sw_grant_o,
  input  logic                     tu_valid_i,
  input  logic [TIMER_WIDTH-1:0]   tu_time_i,
  output logic                     tu_grant_o,
  output logic [PACKET_LEN-1:0]    packet_bits_o,
  output logic [LEN_W-1:0]         packet_len_o,
  output logic                     packet_valid_o,
  input  logic                     packet_ready_i,
  output logic                     fifo_full_o
);

  localparam int unsigned PTRW      = (NSW > 1) ? $clog2(NSW) : 1;
  localparam int unsigned SYNC_LEN  = 4 + 2 + PRIVLEN + 1 + XLEN;
  localparam int unsigned EXC_LEN   = SYNC_LEN + CAUSELEN + 1;

  typedef struct packed {
    logic [PACKET_LEN-1:0] bits;
    logic [LEN_W-1:0]      len;
  } packet_t;

  trdb_format_t    fmt;
  trdb_subformat_t sub;
  logic [XLEN-1:0] last_addr_q, base;
  logic [PTRW-1:0] ptr_q;
  logic            flush_q;
  logic            fifo_empty, fifo_full, can_push;
  logic            trace_bad, trace_push, omit_addr, is_branch_fmt;
  logic            sw_hit, sw_take, tu_take, push;
  int unsigned     sw_sel;
  logic [LEN_W-1:0]      keep, map_len;
  logic [PACKET_LEN-1:0] ones, addr_field, map_field;
  packet_t         trace_pkt, sw_pkt, tu_pkt, push_pkt, head;

  assign fmt           = trdb_format_t'(trace_format_i);
  assign sub           = trdb_subformat_t'(trace_subformat_i);
  assign is_branch_fmt = (fmt == F_BRANCH_FULL) || (fmt == F_BRANCH_DIFF);
  assign trace_bad     = (fmt == F_SYNC) && (sub == SF_CONTEXT || sub == SF_UNDEF);
  assign omit_addr     = is_branch_fmt && branch_map_full_i &&
                         (branch_map_cnt_i == 5'd31) && !lc_u_discontinuity_i;

  // A full FIFO still accepts when its head leaves in the same cycle.
  assign can_push      = !fifo_full || packet_ready_i;
  assign trace_ready_o = trace_valid_i && can_push;
  assign trace_push    = trace_ready_o && !trace_bad;

  always_comb begin
    int unsigned cand;
    sw_hit = 1'b0;
    sw_sel = 0;
    for (int unsigned i = 0; i < NSW; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NSW) cand = cand - NSW;
      if (!sw_hit && sw_valid_i[cand]) begin
        sw_hit = 1'b1;
        sw_sel = cand;
      end
    end
  end

  assign sw_take    = !trace_valid_i && sw_hit && can_push;
  assign sw_grant_o = sw_take ? (NSW'(1) << sw_sel) : '0;
  assign tu_take    = !trace_valid_i && !(|sw_valid_i) && tu_valid_i && can_push;
  assign tu_grant_o = tu_take;
  assign push       = trace_push || sw_take || tu_take;

  always_comb begin
    base       = (use_full_addr_i || fmt == F_BRANCH_FULL || fmt == F_SYNC)
                 ? iaddr_i : last_addr_q - iaddr_i;
    keep       = sign_compress_len(64'(base), XLEN);
    map_len    = branch_map_len(branch_map_cnt_i);
    ones       = '1;
    addr_field = PACKET_LEN'(base) & ~(ones << keep);
    map_field  = PACKET_LEN'(branch_map_i) & ~(ones << map_len);

    trace_pkt           = '0;
    trace_pkt.bits[1:0] = W_TRACE;
    trace_pkt.bits[3:2] = trace_format_i;
    unique case (fmt)
      F_BRANCH_FULL, F_BRANCH_DIFF: begin
        if (omit_addr) begin
          trace_pkt.bits = trace_pkt.bits | (PACKET_LEN'(branch_map_i) << 9);
          trace_pkt.len  = 7'd40;
        end else begin
          trace_pkt.bits[8:4] = branch_map_cnt_i;
          trace_pkt.bits = trace_pkt.bits | (map_field << 9)
                           | (addr_field << (7'd9 + map_len));
          trace_pkt.len  = 7'd9 + map_len + keep;
        end
      end
      F_ADDR_ONLY: begin
        trace_pkt.bits = trace_pkt.bits | (addr_field << 4);
        trace_pkt.len  = 7'd4 + keep;
      end
      F_SYNC: begin
        if (sub == SF_START) begin
          trace_pkt.bits = trace_pkt.bits | (PACKET_LEN'({iaddr_i, is_branch_i, priv_i,
                                                          trace_subformat_i}) << 4);
          trace_pkt.len  = LEN_W'(SYNC_LEN);
        end else if (sub == SF_EXCEPTION) begin
          trace_pkt.bits = trace_pkt.bits | (PACKET_LEN'({interrupt_i, cause_i, iaddr_i,
                                                          is_branch_i, priv_i,
                                                          trace_subformat_i}) << 4);
          trace_pkt.len  = LEN_W'(EXC_LEN);
        end
      end
    endcase
  end

  always_comb begin
    sw_pkt             = '0;
    sw_pkt.bits[1:0]   = W_SOFTWARE;
    sw_pkt.bits[2+:32] = sw_word_i[32*sw_sel +: 32];
    sw_pkt.len         = 7'd34;

    tu_pkt                      = '0;
    tu_pkt.bits[1:0]            = W_TIME;
    tu_pkt.bits[2+:TIMER_WIDTH] = tu_time_i;
    tu_pkt.len                  = LEN_W'(2 + TIMER_WIDTH);

    push_pkt = trace_pkt;
    if (!trace_valid_i) push_pkt = sw_take ? sw_pkt : tu_pkt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    int unsigned nxt;
    if (!rst_ni) begin
      last_addr_q <= '0;
      ptr_q       <= '0;
      flush_q     <= 1'b0;
    end else begin
      flush_q <= trace_push && is_branch_fmt;
      if (trace_push && !omit_addr) last_addr_q <= iaddr_i;
      if (sw_take) begin
        nxt = sw_sel + 1;
        if (nxt >= NSW) nxt = 0;
        ptr_q <= PTRW'(nxt);
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(trace_valid_i && trace_bad))
    else $error("trdb_packet_emitter_mc: unsupported sync subformat dropped");

  trdb_packet_fifo #(
    .DEPTH (DEPTH),
    .T     (packet_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_pkt),
    .pop_i   (packet_ready_i),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign packet_bits_o      = head.bits;
  assign packet_len_o       = head.len;
  assign packet_valid_o     = !fifo_empty;
  assign fifo_full_o        = fifo_full;
  assign branch_map_flush_o = flush_q;

endmodule
